// File: rtl/counter_pkg.sv
// Shared types for the modulo-N counter: counting modes and the bounce direction.
package counter_pkg;

    typedef enum logic [1:0] {
        UP     = 2'b00,
        DOWN   = 2'b01,
        BOUNCE = 2'b10,
        HOLD   = 2'b11
    } cnt_mode_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

endpackage

// File: rtl/mod_n_counter_if.sv
// Control and status bundle of the modulo-N counter; master drives controls, slave is the counter.
interface mod_n_counter_if #(
    parameter int WIDTH = 4
);
    import counter_pkg::*;

    logic             en;
    cnt_mode_t        mode;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] x;
    logic             tc;
    dir_t             dir;
    logic             load_err;

    modport master (
        output en, mode, load, load_val,
        input  x, tc, dir, load_err
    );

    modport slave (
        input  en, mode, load, load_val,
        output x, tc, dir, load_err
    );

endinterface

// File: rtl/mod_counter_next.sv
// Combinational next-state for the counter: next count, next direction and wrap/reversal flag.
module mod_counter_next
    import counter_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int MODULO = 11
) (
    input  logic [WIDTH-1:0] x,
    input  dir_t             dir,
    input  cnt_mode_t        mode,
    output logic [WIDTH-1:0] next_x,
    output dir_t             next_dir,
    output logic             wrap
);

    // Top value held one bit wider so MODULO == 2**WIDTH still fits.
    localparam logic [WIDTH:0]   MAX_X   = (WIDTH+1)'(MODULO - 1);
    localparam logic [WIDTH-1:0] TOP_X   = MAX_X[WIDTH-1:0];
    localparam logic [WIDTH-1:0] TURN_DN = (MODULO >= 2) ? WIDTH'(MODULO - 2) : '0;
    localparam logic [WIDTH-1:0] TURN_UP = (MODULO >= 2) ? WIDTH'(1) : '0;

    logic [WIDTH:0]   x_ext;
    logic [WIDTH-1:0] inc_x;
    logic [WIDTH-1:0] dec_x;
    logic             at_top;
    logic             above_top;
    logic             at_zero;

    assign x_ext     = {1'b0, x};
    assign inc_x     = x + WIDTH'(1);
    assign dec_x     = x - WIDTH'(1);
    assign at_top    = (x_ext == MAX_X);
    assign above_top = (x_ext > MAX_X);
    assign at_zero   = (x == '0);

    always_comb begin
        next_x   = x;
        next_dir = dir;
        wrap     = 1'b0;
        case (mode)
            UP: begin
                next_dir = DIR_UP;
                if (at_top || above_top) begin
                    next_x = '0;
                    wrap   = at_top;
                end else begin
                    next_x = inc_x;
                end
            end
            DOWN: begin
                next_dir = DIR_DOWN;
                if (at_zero) begin
                    next_x = TOP_X;
                    wrap   = 1'b1;
                end else if (above_top) begin
                    next_x = TOP_X;
                end else begin
                    next_x = dec_x;
                end
            end
            BOUNCE: begin
                if (dir == DIR_UP) begin
                    if (above_top) begin
                        next_x = '0;
                    end else if (at_top) begin
                        // Reflect off the top: the top value is shown once, not twice.
                        next_dir = DIR_DOWN;
                        next_x   = TURN_DN;
                        wrap     = 1'b1;
                    end else begin
                        next_x = inc_x;
                    end
                end else begin
                    if (at_zero) begin
                        next_dir = DIR_UP;
                        next_x   = TURN_UP;
                        wrap     = 1'b1;
                    end else if (above_top) begin
                        next_x = TOP_X;
                    end else begin
                        next_x = dec_x;
                    end
                end
            end
            default: begin
                next_x   = x;
                next_dir = dir;
                wrap     = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mod_n_counter.sv
// Modulo-N up/down/bounce counter with synchronous clamped load and registered tc/dir/load_err.
module mod_n_counter
    import counter_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MODULO    = 11,
    parameter int RESET_VAL = 0
) (
    input  logic           clock,
    input  logic           reset,
    mod_n_counter_if.slave bus
);

    generate
        if (MODULO < 1 || MODULO > 2**WIDTH) begin : g_bad_modulo
            $error("mod_n_counter: MODULO must satisfy 1 <= MODULO <= 2**WIDTH");
        end
        if (RESET_VAL < 0 || RESET_VAL >= MODULO) begin : g_bad_reset_val
            $error("mod_n_counter: RESET_VAL must be below MODULO");
        end
    endgenerate

    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULO);
    localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MODULO - 1);
    localparam logic [WIDTH-1:0] TOP_X   = MAX_EXT[WIDTH-1:0];
    localparam logic [WIDTH-1:0] RST_X   = WIDTH'(RESET_VAL);

    logic [WIDTH-1:0] x_q, x_d;
    dir_t             dir_q, dir_d;
    logic             tc_q, tc_d;
    logic             load_err_q, load_err_d;

    logic [WIDTH-1:0] step_x;
    dir_t             step_dir;
    logic             step_wrap;
    logic             clamp;

    mod_counter_next #(
        .WIDTH  (WIDTH),
        .MODULO (MODULO)
    ) u_next (
        .x        (x_q),
        .dir      (dir_q),
        .mode     (bus.mode),
        .next_x   (step_x),
        .next_dir (step_dir),
        .wrap     (step_wrap)
    );

    assign clamp = ({1'b0, bus.load_val} >= MOD_EXT);

    // Load wins over counting regardless of en; tc and load_err default low every cycle.
    always_comb begin
        x_d        = x_q;
        dir_d      = dir_q;
        tc_d       = 1'b0;
        load_err_d = 1'b0;
        if (bus.load) begin
            x_d        = clamp ? TOP_X : bus.load_val;
            load_err_d = clamp;
        end else if (bus.en && bus.mode != HOLD) begin
            x_d   = step_x;
            dir_d = step_dir;
            tc_d  = step_wrap;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            x_q        <= RST_X;
            dir_q      <= DIR_UP;
            tc_q       <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            x_q        <= x_d;
            dir_q      <= dir_d;
            tc_q       <= tc_d;
            load_err_q <= load_err_d;
        end
    end

    assign bus.x        = x_q;
    assign bus.dir      = dir_q;
    assign bus.tc       = tc_q;
    assign bus.load_err = load_err_q;

endmodule

// File: tb/tb_mod_n_counter.sv
// Bench for mod_n_counter: directed scenarios plus randomized traffic against an arithmetic model.
module tb_mod_n_counter;
    import counter_pkg::*;

    localparam int W = 4;

    typedef struct {
        int x;
        int dir;
        int tc;
        int err;
    } mstate_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           en;
    logic           load;
    logic [1:0]     mode_raw;
    logic [W-1:0]   load_val;

    int n_vec = 0;
    int n_err = 0;

    int      mods[3] = '{11, 1, 16};
    mstate_t ms[3];

    logic [W-1:0] ox[3];
    logic         otc[3];
    logic         odir[3];
    logic         oerr[3];

    always #5 clk = ~clk;

    mod_n_counter_if #(.WIDTH(W)) bus0 ();
    mod_n_counter_if #(.WIDTH(W)) bus1 ();
    mod_n_counter_if #(.WIDTH(W)) bus2 ();

    assign bus0.en = en;  assign bus0.load = load;  assign bus0.load_val = load_val;
    assign bus1.en = en;  assign bus1.load = load;  assign bus1.load_val = load_val;
    assign bus2.en = en;  assign bus2.load = load;  assign bus2.load_val = load_val;
    assign bus0.mode = cnt_mode_t'(mode_raw);
    assign bus1.mode = cnt_mode_t'(mode_raw);
    assign bus2.mode = cnt_mode_t'(mode_raw);

    assign ox[0] = bus0.x;  assign otc[0] = bus0.tc;  assign odir[0] = bus0.dir;  assign oerr[0] = bus0.load_err;
    assign ox[1] = bus1.x;  assign otc[1] = bus1.tc;  assign odir[1] = bus1.dir;  assign oerr[1] = bus1.load_err;
    assign ox[2] = bus2.x;  assign otc[2] = bus2.tc;  assign odir[2] = bus2.dir;  assign oerr[2] = bus2.load_err;

    mod_n_counter #(.WIDTH(W), .MODULO(11), .RESET_VAL(0)) dut_m11 (
        .clock (clk), .reset (rst), .bus (bus0.slave)
    );
    mod_n_counter #(.WIDTH(W), .MODULO(1), .RESET_VAL(0)) dut_m1 (
        .clock (clk), .reset (rst), .bus (bus1.slave)
    );
    mod_n_counter #(.WIDTH(W), .MODULO(16), .RESET_VAL(0)) dut_m16 (
        .clock (clk), .reset (rst), .bus (bus2.slave)
    );

    // Reference: sequence rules expressed with modular arithmetic on plain integers.
    function automatic mstate_t ref_next(mstate_t s, int m, bit ld, int lv, bit e, int md);
        mstate_t n;
        n     = s;
        n.tc  = 0;
        n.err = 0;
        if (ld) begin
            n.x   = (lv < m) ? lv : m - 1;
            n.err = (lv >= m) ? 1 : 0;
        end else if (e && md != 3) begin
            if (md == 0) begin
                n.dir = 0;
                n.x   = (s.x + 1) % m;
                n.tc  = (s.x == m - 1) ? 1 : 0;
            end else if (md == 1) begin
                n.dir = 1;
                n.x   = (s.x + m - 1) % m;
                n.tc  = (s.x == 0) ? 1 : 0;
            end else if (s.dir == 0) begin
                if (s.x == m - 1) begin
                    n.dir = 1;
                    n.x   = (m >= 2) ? m - 2 : 0;
                    n.tc  = 1;
                end else begin
                    n.x = s.x + 1;
                end
            end else begin
                if (s.x == 0) begin
                    n.dir = 0;
                    n.x   = (m >= 2) ? 1 : 0;
                    n.tc  = 1;
                end else begin
                    n.x = s.x - 1;
                end
            end
        end
        return n;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            ms[i].x = 0; ms[i].dir = 0; ms[i].tc = 0; ms[i].err = 0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        for (int i = 0; i < 3; i++)
            ms[i] = ref_next(ms[i], mods[i], load, int'(load_val), en, int'(mode_raw));
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; load = 1'b0; mode_raw = 2'd0; load_val = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (ox[i] !== 4'd0 || otc[i] !== 1'b0 || odir[i] !== 1'b0 || oerr[i] !== 1'b0) begin
                n_err++;
                $display("FAIL reset dut%0d: got x=%0d tc=%0b dir=%0b err=%0b expected 0/0/0/0",
                         i, ox[i], otc[i], odir[i], oerr[i]);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_up();
        int exp_x;
        mode_raw = 2'd0; en = 1'b1;
        for (int k = 0; k < 12; k++) begin
            step();
            exp_x = (k < 10) ? k + 1 : (k == 10 ? 0 : 1);
            n_vec++;
            if (int'(ox[0]) !== exp_x || otc[0] !== (k == 10) || odir[0] !== 1'b0) begin
                n_err++;
                $display("FAIL up step %0d: got x=%0d tc=%0b dir=%0b expected x=%0d tc=%0b dir=0",
                         k, ox[0], otc[0], odir[0], exp_x, (k == 10));
            end
            $display("up step %0d: x=%0d tc=%0b", k, ox[0], otc[0]);
        end
    endtask

    task automatic test_down();
        int exp_x[4] = '{1, 0, 10, 9};
        load = 1'b1; load_val = 4'd2; en = 1'b0;
        step();
        load = 1'b0; mode_raw = 2'd1; en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            n_vec++;
            if (int'(ox[0]) !== exp_x[k] || otc[0] !== (k == 2) || odir[0] !== 1'b1) begin
                n_err++;
                $display("FAIL down step %0d: got x=%0d tc=%0b dir=%0b expected x=%0d tc=%0b dir=1",
                         k, ox[0], otc[0], odir[0], exp_x[k], (k == 2));
            end
            $display("down step %0d: x=%0d tc=%0b dir=%0b", k, ox[0], otc[0], odir[0]);
        end
    endtask

    task automatic test_bounce();
        int   exp_x[4] = '{9, 10, 9, 8};
        logic exp_d[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        load = 1'b1; load_val = 4'd7; en = 1'b1;
        step();
        load = 1'b0; mode_raw = 2'd0;
        step();
        mode_raw = 2'd2;
        for (int k = 0; k < 4; k++) begin
            step();
            n_vec++;
            if (int'(ox[0]) !== exp_x[k] || otc[0] !== (k == 2) || odir[0] !== exp_d[k]) begin
                n_err++;
                $display("FAIL bounce step %0d: got x=%0d tc=%0b dir=%0b expected x=%0d tc=%0b dir=%0b",
                         k, ox[0], otc[0], odir[0], exp_x[k], (k == 2), exp_d[k]);
            end
            $display("bounce step %0d: x=%0d tc=%0b dir=%0b", k, ox[0], otc[0], odir[0]);
        end
        load = 1'b1; load_val = 4'd0;
        step();
        n_vec++;
        if (ox[0] !== 4'd0 || odir[0] !== 1'b1 || otc[0] !== 1'b0) begin
            n_err++;
            $display("FAIL bounce_load0: got x=%0d dir=%0b tc=%0b expected x=0 dir=1 tc=0",
                     ox[0], odir[0], otc[0]);
        end
        load = 1'b0;
        step();
        n_vec++;
        if (ox[0] !== 4'd1 || odir[0] !== 1'b0 || otc[0] !== 1'b1) begin
            n_err++;
            $display("FAIL bounce_floor: got x=%0d dir=%0b tc=%0b expected x=1 dir=0 tc=1",
                     ox[0], odir[0], otc[0]);
        end
        $display("bounce floor: x=%0d dir=%0b tc=%0b", ox[0], odir[0], otc[0]);
    endtask

    task automatic test_load();
        load = 1'b1; en = 1'b1; mode_raw = 2'd0; load_val = 4'd13;
        step();
        n_vec++;
        if (ox[0] !== 4'd10 || oerr[0] !== 1'b1 || otc[0] !== 1'b0) begin
            n_err++;
            $display("FAIL load_clamp: got x=%0d err=%0b tc=%0b expected x=10 err=1 tc=0",
                     ox[0], oerr[0], otc[0]);
        end
        load_val = 4'd5;
        step();
        n_vec++;
        if (ox[0] !== 4'd5 || oerr[0] !== 1'b0 || otc[0] !== 1'b0) begin
            n_err++;
            $display("FAIL load_ok: got x=%0d err=%0b tc=%0b expected x=5 err=0 tc=0",
                     ox[0], oerr[0], otc[0]);
        end
        load = 1'b0; en = 1'b0;
        step();
        n_vec++;
        if (ox[0] !== 4'd5 || oerr[0] !== 1'b0) begin
            n_err++;
            $display("FAIL load_idle: got x=%0d err=%0b expected x=5 err=0", ox[0], oerr[0]);
        end
        $display("load: x=%0d err=%0b", ox[0], oerr[0]);
    endtask

    task automatic test_async_reset();
        load = 1'b1; load_val = 4'd8; en = 1'b1;
        step();
        load = 1'b0; mode_raw = 2'd1;
        step();
        mode_raw = 2'd2;
        n_vec++;
        if (ox[0] !== 4'd7 || odir[0] !== 1'b1) begin
            n_err++;
            $display("FAIL pre_reset: got x=%0d dir=%0b expected x=7 dir=1", ox[0], odir[0]);
        end
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        #1;
        n_vec++;
        if (ox[0] !== 4'd0 || odir[0] !== 1'b0 || otc[0] !== 1'b0 || oerr[0] !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset: got x=%0d dir=%0b tc=%0b err=%0b expected all 0",
                     ox[0], odir[0], otc[0], oerr[0]);
        end
        $display("async reset: x=%0d dir=%0b", ox[0], odir[0]);
        #2;
        rst = 1'b0;
        #1;
    endtask

    task automatic test_edge_moduli();
        en = 1'b1; load = 1'b0;
        for (int md = 0; md < 3; md++) begin
            mode_raw = 2'(md);
            for (int k = 0; k < 3; k++) begin
                step();
                n_vec++;
                if (ox[1] !== 4'd0 || otc[1] !== 1'b1) begin
                    n_err++;
                    $display("FAIL m1 mode %0d step %0d: got x=%0d tc=%0b expected x=0 tc=1",
                             md, k, ox[1], otc[1]);
                end
            end
        end
        load = 1'b1; load_val = 4'd14;
        step();
        load = 1'b0; mode_raw = 2'd0;
        step();
        n_vec++;
        if (ox[2] !== 4'd15 || otc[2] !== 1'b0) begin
            n_err++;
            $display("FAIL m16_top: got x=%0d tc=%0b expected x=15 tc=0", ox[2], otc[2]);
        end
        step();
        n_vec++;
        if (ox[2] !== 4'd0 || otc[2] !== 1'b1) begin
            n_err++;
            $display("FAIL m16_wrap: got x=%0d tc=%0b expected x=0 tc=1", ox[2], otc[2]);
        end
        $display("m16 wrap: x=%0d tc=%0b", ox[2], otc[2]);
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            en       = ($urandom_range(0, 3) != 0);
            mode_raw = 2'($urandom_range(0, 3));
            load     = ($urandom_range(0, 7) == 0);
            load_val = W'($urandom_range(0, 15));
            step();
            for (int i = 0; i < 3; i++) begin
                n_vec++;
                if (int'(ox[i]) !== ms[i].x || int'(otc[i]) !== ms[i].tc ||
                    int'(odir[i]) !== ms[i].dir || int'(oerr[i]) !== ms[i].err) begin
                    n_err++;
                    $display("FAIL random %0d dut%0d: got x=%0d tc=%0b dir=%0b err=%0b expected x=%0d tc=%0d dir=%0d err=%0d",
                             k, i, ox[i], otc[i], odir[i], oerr[i], ms[i].x, ms[i].tc, ms[i].dir, ms[i].err);
                end
            end
            $display("random %0d: en=%0b mode=%0d load=%0b val=%0d x=%0d/%0d/%0d",
                     k, en, mode_raw, load, load_val, ox[0], ox[1], ox[2]);
        end
    endtask

    initial begin
        test_reset();
        test_up();
        test_down();
        test_bounce();
        test_load();
        test_async_reset();
        test_edge_moduli();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
